// File: rtl/osc_adj_cal.sv
// Oscillator calibration: counts osc_in edges per window and steps ctrl by +/-1 until within tol.
// Define OSC_ADJ_CAL_TRACK_EN to keep measuring while locked and re-adjust when the count drifts.
module osc_adj_cal #(
   parameter int unsigned CTRL_W     = 2,
   parameter int unsigned CNT_W      = 10,
   parameter int unsigned WIN_CYC    = 64,
   parameter int unsigned SETTLE_CYC = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              osc_in,
   input  logic [CNT_W-1:0]  target,
   input  logic [CNT_W-1:0]  tol,
   output logic [CTRL_W-1:0] ctrl,
   output logic              busy,
   output logic              locked,
   output logic              fail,
   output logic [CNT_W-1:0]  meas
);

   localparam int unsigned TimerW = $clog2(WIN_CYC > SETTLE_CYC ? WIN_CYC : SETTLE_CYC) + 1;
   localparam int unsigned IterW  = CTRL_W + 1;

   localparam logic [TimerW-1:0] SettleLast = TimerW'(SETTLE_CYC - 1);
   localparam logic [TimerW-1:0] WinLast    = TimerW'(WIN_CYC - 1);
   localparam logic [IterW-1:0]  IterMax    = IterW'((1 << CTRL_W) + 1);
   localparam logic [CTRL_W-1:0] CtrlMid    = CTRL_W'(1) << (CTRL_W - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StMeasure,
      StEval,
      StLocked,
      StFail
   } state_e;

   state_e             state_q;
   logic [TimerW-1:0]  timer_q;
   logic [IterW-1:0]   iter_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic [CNT_W-1:0]   eval_cnt;
   logic [CNT_W:0]     err;
   logic               sync1_q;
   logic               sync2_q;
   logic               prev_q;
   logic               osc_rise;
   logic               below;
   logic               in_tol;
   logic               at_limit;
   logic               can_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= osc_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign osc_rise  = sync2_q & ~prev_q;
   assign can_start = (state_q == StIdle) || (state_q == StLocked) || (state_q == StFail);
   assign at_limit  = (iter_q + 1'b1) == IterMax;

   // EVAL judges the held count; a tracking window judges the count including its last cycle.
   always_comb begin
      cnt_inc = cnt_q;
      if (osc_rise && (cnt_q != '1)) begin
         cnt_inc = cnt_q + 1'b1;
      end
      eval_cnt = (state_q == StEval) ? cnt_q : cnt_inc;
      below    = eval_cnt < target;
      if (below) begin
         err = {1'b0, target} - {1'b0, eval_cnt};
      end else begin
         err = {1'b0, eval_cnt} - {1'b0, target};
      end
      in_tol = err <= {1'b0, tol};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         timer_q <= '0;
         iter_q  <= '0;
         cnt_q   <= '0;
         ctrl    <= '0;
         meas    <= '0;
         busy    <= 1'b0;
         locked  <= 1'b0;
         fail    <= 1'b0;
      end else if (start && can_start) begin
         state_q <= StSettle;
         timer_q <= '0;
         iter_q  <= '0;
         ctrl    <= CtrlMid;
         busy    <= 1'b1;
         locked  <= 1'b0;
         fail    <= 1'b0;
      end else begin
         case (state_q)
            StSettle: begin
               if (timer_q == SettleLast) begin
                  state_q <= StMeasure;
                  timer_q <= '0;
                  cnt_q   <= '0;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StMeasure: begin
               cnt_q <= cnt_inc;
               if (timer_q == WinLast) begin
                  state_q <= StEval;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StEval: begin
               meas   <= cnt_q;
               iter_q <= iter_q + 1'b1;
               if (in_tol) begin
                  state_q <= StLocked;
                  timer_q <= '0;
                  cnt_q   <= '0;
                  busy    <= 1'b0;
                  locked  <= 1'b1;
               end else if (at_limit || (below && (ctrl == '1)) || (!below && (ctrl == '0))) begin
                  state_q <= StFail;
                  busy    <= 1'b0;
                  fail    <= 1'b1;
               end else begin
                  state_q <= StSettle;
                  timer_q <= '0;
                  ctrl    <= below ? ctrl + 1'b1 : ctrl - 1'b1;
               end
            end
            StLocked: begin
`ifdef OSC_ADJ_CAL_TRACK_EN
               cnt_q <= cnt_inc;
               if (timer_q == WinLast) begin
                  timer_q <= '0;
                  if (in_tol) begin
                     meas  <= cnt_inc;
                     cnt_q <= '0;
                  end else begin
                     // Hand the drifted count to EVAL, which reports it and steps ctrl.
                     state_q <= StEval;
                     iter_q  <= '0;
                     busy    <= 1'b1;
                     locked  <= 1'b0;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
`else
               cnt_q <= cnt_q;
`endif
            end
            default: begin
               cnt_q <= cnt_q;
            end
         endcase
      end
   end

endmodule

// File: doc/osc_adj_cal.md
OSC_ADJ_CAL -- requirements
Module: osc_adj_cal

Interface
REQ-001 SHALL have parameter CTRL_W, default 2: width of oscillator control code.
REQ-002 SHALL have parameter CNT_W, default 10: width of edge counter, target, tolerance and measurement.
REQ-003 SHALL have parameter WIN_CYC, default 64: measurement window length in clk cycles.
REQ-004 SHALL have parameter SETTLE_CYC, default 8: wait in clk cycles after every ctrl change.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: calibration request, sampled each cycle.
REQ-008 SHALL have port osc_in, input, 1: oscillator output, asynchronous to clk.
REQ-009 SHALL have port target, input, CNT_W: desired osc_in rising edges per window.
REQ-010 SHALL have port tol, input, CNT_W: permitted absolute error in edges.
REQ-011 SHALL have port ctrl, output, CTRL_W: oscillator control code; larger code means higher frequency.
REQ-012 SHALL have port busy, locked, fail, outputs, 1 each: status flags.
REQ-013 SHALL have port meas, output, CNT_W: edge count from the most recent window.

Function
REQ-014 SHALL synchronise osc_in through two flops and count one edge per cycle where synced value is 1 and its previous value was 0.
REQ-015 Edge counter SHALL saturate at all-ones and SHALL never wrap.
REQ-016 SHALL implement states IDLE, SETTLE, MEASURE, EVAL, LOCKED, FAIL.
REQ-017 On start in IDLE, LOCKED or FAIL: ctrl <= 2^(CTRL_W-1), iteration count cleared, next state SETTLE. start in SETTLE/MEASURE/EVAL SHALL be ignored.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then MEASURE. The edge counter SHALL clear on entry to MEASURE.
REQ-019 MEASURE SHALL last exactly WIN_CYC cycles, then EVAL, which lasts exactly one cycle.
REQ-020 In EVAL: meas <= count; the error SHALL be computed as |count - target| in CNT_W+1 bits with no overflow.
REQ-021 EVAL: if error <= tol, go to LOCKED with ctrl unchanged.
REQ-022 EVAL: if count < target and ctrl = all-ones, go to FAIL. Otherwise, if count < target, ctrl <= ctrl+1 and go to SETTLE.
REQ-023 EVAL: if count > target and ctrl = 0, go to FAIL. Otherwise, if count > target, ctrl <= ctrl-1 and go to SETTLE.
REQ-024 The iteration counter SHALL increment in each EVAL. An EVAL that would not lock when the count reaches 2^CTRL_W+1 SHALL go to FAIL, preventing dither.
REQ-025 busy SHALL be 1 exactly in SETTLE, MEASURE and EVAL; locked SHALL be 1 exactly in LOCKED; fail SHALL be 1 exactly in FAIL.
REQ-026 All outputs SHALL be registered.
REQ-027 First EVAL SHALL occur 1+SETTLE_CYC+WIN_CYC cycles after the start cycle.
REQ-028 target and tol SHALL be sampled only in EVAL.

Reset
REQ-029 With rst=1 at a clk edge: state=IDLE, ctrl=0, meas=0, busy=locked=fail=0, counters and synchronisers cleared.
REQ-030 rst SHALL take priority over start and over every state, including mid-MEASURE.

Configuration
REQ-031 Macro OSC_ADJ_CAL_TRACK_EN defined: LOCKED SHALL repeatedly run SETTLE-less windows of WIN_CYC cycles, updating meas after each. If error > tol, locked SHALL drop and the FSM SHALL re-enter EVAL adjustment from the current ctrl with the iteration count cleared.
REQ-032 Macro undefined: LOCKED SHALL hold ctrl and meas until start or rst; no tracking logic SHALL be present.

Verification
REQ-033 Reset: assert rst 2 cycles at random state -> ctrl=0, meas=0, busy=locked=fail=0.
REQ-034 Bench oscillator gives 4*(ctrl+1) edges/window; target=12, tol=0; pulse start -> ctrl=2, first EVAL at cycle 73, meas=12, locked=1.
REQ-035 Same model; target=13, tol=0 -> ctrl sequence 2,3,2,3,2, then fail=1 after the 5th EVAL.
REQ-036 Same model; target=40, tol=2 -> ctrl 2 to 3, meas=16, fail=1 with ctrl=3; start while busy has no effect.
REQ-037 rst asserted 20 cycles into MEASURE -> all outputs at reset values next cycle; a fresh start recalibrates normally.
REQ-038 TRACK_EN: lock at target=12, then model changes to 2*(ctrl+1) edges -> locked=0 after the next window, ctrl climbs to 3 and locks at meas=8 when tol=4.
